pov_column_sequencer: RTL and testbench

Upstream feeder for led_driver in the POV clock. Measures rotation period from a hall-effect index sensor and divides each revolution into NUM_COLS equal column slots. At each slot it reads that column's 8-LED RGB data from an internal framebuffer and presents it on led_r/g/b_vector with a one-cycle write_data strobe. The framebuffer is loaded by the image/clock-face generator through a simple write port.

---
 rtl/pov_column_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pov_column_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_column_sequencer.sv
// POV column sequencer: times column slots from the hall index and streams framebuffer columns.
// Latency: column 0 loads 3 cycles after a hall rising edge; write_data can fire the next cycle.
// Backpressure: write_data waits for driver_ready; a newer emit replaces the pending frame and pulses overrun.
module pov_column_sequencer #(
  parameter int NUM_COLS = 64,
  parameter int COL_W    = 6,
  parameter int PERIOD_W = 24
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               hall_in,
  input  logic               driver_ready,
  input  logic               fb_we,
  input  logic [COL_W-1:0]   fb_col,
  input  logic [191:0]       fb_data,
  output logic [63:0]        led_r_vector,
  output logic [63:0]        led_g_vector,
  output logic [63:0]        led_b_vector,
  output logic               write_data,
  output logic [COL_W-1:0]   column,
  output logic               running,
  output logic               overrun
);

  localparam int               CP_W     = PERIOD_W - COL_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                hall_s1;
  logic                hall_s2;
  logic                hall_s3;
  logic                index;
  logic [PERIOD_W-1:0] rev_cnt;
  logic [PERIOD_W-1:0] period_new;
  logic                rev_sat;
  logic                timeout;
  logic [CP_W-1:0]     cp_raw;
  logic [CP_W-1:0]     cp_new;
  logic [CP_W-1:0]     col_period;
  logic [CP_W-1:0]     tick;
  logic                tick_term;
  logic                last_col;
  logic                emit;
  logic                blank;
  logic                capture;
  logic                advance;
  logic [COL_W-1:0]    emit_col;
  logic [191:0]        fb [NUM_COLS];
  logic [191:0]        fb_rd;
  logic                pending;

  // Index detection: the pulse marks column 0 and restarts the period measurement.
  assign index   = hall_s2 & ~hall_s3;
  assign rev_sat = &rev_cnt;
  // An index arriving on the saturation cycle still counts as a valid revolution.
  assign timeout = rev_sat & ~index;

  // A saturated counter cannot be incremented, so the measured period clamps at all-ones.
  assign period_new = rev_sat ? rev_cnt : rev_cnt + PERIOD_W'(1);
  assign cp_raw     = CP_W'(period_new >> COL_W);
  assign cp_new     = (cp_raw == '0) ? CP_W'(1) : cp_raw;

  assign tick_term = (tick == col_period - CP_W'(1));
  assign last_col  = (column == LAST_COL);

  // A capture restarts at column 0; otherwise the emit targets the next column.
  assign emit_col = capture ? '0 : column + COL_W'(1);
  assign fb_rd    = fb[emit_col];

  assign write_data = pending & driver_ready;
  assign running    = (state == RUN);

  // Synchronize hall_in and keep one extra stage for rising-edge detection.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      hall_s1 <= 1'b0;
      hall_s2 <= 1'b0;
      hall_s3 <= 1'b0;
    end else begin
      hall_s1 <= hall_in;
      hall_s2 <= hall_s1;
      hall_s3 <= hall_s2;
    end
  end

  // Revolution counter: clears on index and saturates so a stopped rotor is detectable.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rev_cnt <= '0;
    end else if (index) begin
      rev_cnt <= '0;
    end else if (!rev_sat) begin
      rev_cnt <= rev_cnt + PERIOD_W'(1);
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode. Index beats both timeout and tick terminal count.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    blank     = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (index) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (index) begin
          capture   = 1'b1;
          emit      = 1'b1;
          state_nxt = RUN;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (index) begin
          capture = 1'b1;
          emit    = 1'b1;
        end else if (timeout) begin
          emit      = 1'b1;
          blank     = 1'b1;
          state_nxt = IDLE;
        end else if (tick_term && !last_col) begin
          advance = 1'b1;
          emit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column timing: slot tick counter, column pointer and latched slot length.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      col_period <= '0;
      tick       <= '0;
      column     <= '0;
    end else if (capture) begin
      col_period <= cp_new;
      tick       <= '0;
      column     <= '0;
    end else begin
      if (state == RUN) tick <= tick_term ? '0 : tick + CP_W'(1);
      if (advance) column <= column + COL_W'(1);
    end
  end

  // Output frame register with a single-entry pending flag; the latest emit wins.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      led_r_vector <= '0;
      led_g_vector <= '0;
      led_b_vector <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (emit) begin
        {led_b_vector, led_g_vector, led_r_vector} <= blank ? 192'd0 : fb_rd;
        pending <= 1'b1;
      end else if (driver_ready) begin
        pending <= 1'b0;
      end
      overrun <= emit & pending & ~driver_ready;
    end
  end

  // Framebuffer storage; not reset so image content survives a sequencer reset.
  always_ff @(posedge sys_clk) begin
    if (fb_we) fb[fb_col] <= fb_data;
  end

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Directed bench for pov_column_sequencer with a small geometry: 8 columns, 10-bit period counter.
// Hall periods of 400/200 cycles give 50/25-cycle column slots; timeout after 1023 idle cycles.
// Strobes are logged by a monitor and compared against a hand-built expected list at the end.
module tb_pov_column_sequencer;
  localparam int NC = 8;
  localparam int CW = 3;
  localparam int PW = 10;

  logic          sys_clk      = 1'b0;
  logic          rst          = 1'b0;
  logic          hall_in      = 1'b0;
  logic          driver_ready = 1'b1;
  logic          fb_we        = 1'b0;
  logic [CW-1:0] fb_col       = '0;
  logic [191:0]  fb_data      = '0;
  logic [63:0]   led_r_vector;
  logic [63:0]   led_g_vector;
  logic [63:0]   led_b_vector;
  logic          write_data;
  logic [CW-1:0] column;
  logic          running;
  logic          overrun;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ovr_cnt     = 0;
  int h1, h2, h3, h4, h5, h6, h7, h8;
  logic [7:0] bv;

  int          mon_cyc[$];
  int          mon_col[$];
  logic [63:0] mon_r[$];
  logic [63:0] mon_g[$];
  logic [63:0] mon_b[$];
  int          exp_cyc[$];
  int          exp_col[$];
  logic [63:0] exp_r[$];
  logic [63:0] exp_g[$];
  logic [63:0] exp_b[$];
  logic [63:0] mr[NC];
  logic [63:0] mg[NC];
  logic [63:0] mb[NC];

  pov_column_sequencer #(.NUM_COLS(NC), .COL_W(CW), .PERIOD_W(PW)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .hall_in      (hall_in),
    .driver_ready (driver_ready),
    .fb_we        (fb_we),
    .fb_col       (fb_col),
    .fb_data      (fb_data),
    .led_r_vector (led_r_vector),
    .led_g_vector (led_g_vector),
    .led_b_vector (led_b_vector),
    .write_data   (write_data),
    .column       (column),
    .running      (running),
    .overrun      (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log every accepted strobe and count overrun cycles, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rst) begin
      if (write_data) begin
        mon_cyc.push_back(cyc);
        mon_col.push_back(int'(column));
        mon_r.push_back(led_r_vector);
        mon_g.push_back(led_g_vector);
        mon_b.push_back(led_b_vector);
      end
      if (overrun) ovr_cnt = ovr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic exp_push(input int c_at, input int col, input logic [63:0] r,
                          input logic [63:0] g, input logic [63:0] b);
    exp_cyc.push_back(c_at);
    exp_col.push_back(col);
    exp_r.push_back(r);
    exp_g.push_back(g);
    exp_b.push_back(b);
  endtask

  // Column c of a revolution whose hall edge was driven in cycle h strobes at h+3+cp*c.
  task automatic exp_rev(input int h, input int cp, input int first, input int last);
    for (int c = first; c <= last; c++) exp_push(h + 3 + cp * c, c, mr[c], mg[c], mb[c]);
  endtask

  initial begin
    // Reset held with the hall input toggling.
    rst = 1'b0;
    repeat (6) begin
      @(posedge sys_clk);
      #1;
      hall_in = ~hall_in;
    end
    hall_in = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_r", led_r_vector, 64'd0);
    chk("rst_g", led_g_vector, 64'd0);
    chk("rst_b", led_b_vector, 64'd0);
    chk("rst_wd", write_data, 1'b0);
    chk("rst_col", column, 3'd0);
    chk("rst_run", running, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b1;

    // Load a distinct pattern per column.
    for (int c = 0; c < NC; c++) begin
      bv    = 8'h80 + 8'(c);
      mr[c] = {8{bv}};
      bv    = 8'(c * 16 + 1);
      mg[c] = {8{bv}};
      mb[c] = {8{8'hFF}};
      fb_we   = 1'b1;
      fb_col  = CW'(c);
      fb_data = {mb[c], mg[c], mr[c]};
      @(posedge sys_clk);
      #1;
    end
    fb_we = 1'b0;

    // No hall edge for longer than the counter range: stays idle, no strobes.
    go_to(cyc + 1100);
    chk("idle_run", running, 1'b0);
    chk("idle_nostrobe", mon_cyc.size(), 0);

    // First edge only arms measurement; second edge starts the revolution.
    h1 = cyc;
    hall_in = 1'b1;
    go_to(h1 + 20); hall_in = 1'b0;
    go_to(h1 + 300);
    chk("measure_run", running, 1'b0);

    h2 = h1 + 400;
    go_to(h2); hall_in = 1'b1;
    exp_rev(h2, 50, 0, 7);
    go_to(h2 + 10);
    chk("run_running", running, 1'b1);
    chk("run_col0", column, 3'd0);
    go_to(h2 + 20); hall_in = 1'b0;
    go_to(h2 + 108);
    chk("run_col2", column, 3'd2);

    // Driver stalls after column 0 is accepted: columns 1..3 pile up, two overruns.
    h3 = h2 + 400;
    go_to(h3); hall_in = 1'b1;
    exp_push(h3 + 3, 0, mr[0], mg[0], mb[0]);
    exp_push(h3 + 154, 3, mr[3], mg[3], mb[3]);
    exp_rev(h3, 50, 4, 7);
    go_to(h3 + 4); driver_ready = 1'b0;
    go_to(h3 + 20); hall_in = 1'b0;
    go_to(h3 + 154); driver_ready = 1'b1;
    go_to(h3 + 160);
    chk("ovr_count", ovr_cnt, 2);

    // Long-to-short transition: index at column 4's slot restarts at column 0.
    h4 = h3 + 400;
    go_to(h4); hall_in = 1'b1;
    exp_rev(h4, 50, 0, 3);
    go_to(h4 + 20); hall_in = 1'b0;

    h5 = h4 + 200;
    go_to(h5); hall_in = 1'b1;
    exp_rev(h5, 25, 0, 7);
    go_to(h5 + 20); hall_in = 1'b0;
    // Rewrite column 5 on the very edge it is emitted: old data now, new data next revolution.
    go_to(h5 + 127);
    mr[5] = {8{8'h55}};
    mg[5] = {8{8'hAA}};
    mb[5] = {8{8'h0F}};
    fb_we   = 1'b1;
    fb_col  = 3'd5;
    fb_data = {mb[5], mg[5], mr[5]};
    go_to(h5 + 128); fb_we = 1'b0;

    // Last revolution, then the rotor stops: one blank frame at saturation.
    h6 = h5 + 200;
    go_to(h6); hall_in = 1'b1;
    exp_rev(h6, 25, 0, 7);
    exp_push(h6 + 1027, -1, 64'd0, 64'd0, 64'd0);
    go_to(h6 + 20); hall_in = 1'b0;
    go_to(h6 + 1020);
    chk("pre_to_run", running, 1'b1);
    go_to(h6 + 1030);
    chk("to_run", running, 1'b0);
    chk("to_r", led_r_vector, 64'd0);
    chk("to_g", led_g_vector, 64'd0);
    chk("to_b", led_b_vector, 64'd0);

    // Resuming needs two edges; the first emits nothing.
    h7 = cyc;
    hall_in = 1'b1;
    go_to(h7 + 20); hall_in = 1'b0;
    go_to(h7 + 300);
    chk("resume_run", running, 1'b0);
    chk("resume_nostrobe", mon_cyc.size(), exp_cyc.size());

    h8 = h7 + 400;
    go_to(h8); hall_in = 1'b1;
    exp_push(h8 + 3, 0, mr[0], mg[0], mb[0]);
    go_to(h8 + 20); hall_in = 1'b0;

    // Asynchronous reset in the middle of column 1's strobe cycle.
    go_to(h8 + 53);
    chk("pre_rst_wd", write_data, 1'b1);
    chk("pre_rst_col", column, 3'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_r", led_r_vector, 64'd0);
    chk("arst_g", led_g_vector, 64'd0);
    chk("arst_b", led_b_vector, 64'd0);
    chk("arst_wd", write_data, 1'b0);
    chk("arst_col", column, 3'd0);
    chk("arst_run", running, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;

    // Strobe-by-strobe comparison against the expected schedule.
    chk("strobe_count", mon_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
      chk($sformatf("s%0d_cyc", i), mon_cyc[i], exp_cyc[i]);
      if (exp_col[i] >= 0) chk($sformatf("s%0d_col", i), mon_col[i], exp_col[i]);
      chk($sformatf("s%0d_r", i), mon_r[i], exp_r[i]);
      chk($sformatf("s%0d_g", i), mon_g[i], exp_g[i]);
      chk($sformatf("s%0d_b", i), mon_b[i], exp_b[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
